// File: rtl/point_encode_25519.sv
// ---------------------------------------------------------------------------
// point_encode_25519
//
// Purpose:
//   Takes the projective (X, Y, Z) result of the Ed25519 extended-coordinate
//   adder/doubler and produces the 256-bit compressed encoding {x[0], y}.
//   Z^-1 = Z^(p-2) mod p is computed by left-to-right square-and-multiply on
//   one shared modular multiplier. The affine coordinates are then formed as
//   x = X*Z^-1 and y = Y*Z^-1.
//
// Ports (point_encode_25519):
//   clk      in   1    clock
//   rst      in   1    asynchronous, active-low reset
//   start    in   1    one-cycle request, only honoured while idle
//   x_in     in   255  projective X
//   y_in     in   255  projective Y
//   z_in     in   255  projective Z
//   enc_out  out  256  compressed point {sign, y}
//   done     out  1    one-cycle pulse, enc_out/err valid
//   err      out  1    Z congruent to 0 mod p
//   busy     out  1    high whenever the controller is not idle
//
// Ports (mul_25519):
//   clk, rst           clock and asynchronous active-low reset
//   i_start            one-cycle pulse; operands are captured on this edge
//   i_a, i_b           operands, any value below 2^255
//   o_done             one-cycle pulse, o_result valid
//   o_result           a*b mod p, fully reduced into [0, p-1]
// ---------------------------------------------------------------------------

module mul_25519 (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic [254:0] i_a,
    input  logic [254:0] i_b,
    output logic         o_done,
    output logic [254:0] o_result
);

    localparam logic [254:0] P = 255'h7fffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffed;

    logic         r_busy;
    logic [2:0]   r_cnt;
    logic [254:0] r_a;
    logic [255:0] r_b;
    logic [254:0] r_acc;
    logic         r_done;

    logic [287:0] w_sum;
    logic [255:0] w_fold1;
    logic [255:0] w_fold2;
    logic [254:0] w_next;

    // One digit-serial step: acc = (acc*2^32 + a*digit) mod p, taking the
    // 32-bit digits of b from the most significant end. Since 2^255 = 19
    // (mod p), the bits above 255 are folded back in with a *19. The second
    // fold can only carry when the first fold left a tiny low part, so after
    // it the value is below 2^255 and a single conditional subtract of p
    // leaves it canonical.
    always_comb begin
        w_sum   = {1'b0, r_acc, 32'd0} + 288'(r_a) * 288'(r_b[255:224]);
        w_fold1 = {1'b0, w_sum[254:0]} + 256'(w_sum[287:255]) * 256'd19;
        w_fold2 = {1'b0, w_fold1[254:0]} + (w_fold1[255] ? 256'd19 : 256'd0);
        if (w_fold2 >= {1'b0, P}) begin
            w_next = w_fold2[254:0] - P;
        end else begin
            w_next = w_fold2[254:0];
        end
    end

    // Operand capture on start, then eight digit steps; the done pulse
    // follows the cycle of the last step so the result is stable with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= 1'b0;
            r_cnt  <= 3'd0;
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start && !r_busy) begin
                r_a    <= i_a;
                r_b    <= {1'b0, i_b};
                r_acc  <= '0;
                r_cnt  <= 3'd7;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_acc <= w_next;
                r_b   <= {r_b[223:0], 32'd0};
                r_cnt <= r_cnt - 3'd1;
                if (r_cnt == 3'd0) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_done   = r_done;
    assign o_result = r_acc;

endmodule

module point_encode_25519 (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [254:0] x_in,
    input  logic [254:0] y_in,
    input  logic [254:0] z_in,
    output logic [255:0] enc_out,
    output logic         done,
    output logic         err,
    output logic         busy
);

    localparam logic [254:0] P = 255'h7fffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffed;
    localparam logic [254:0] E = 255'h7fffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffeb;

    typedef enum logic [3:0] {
        IDLE,
        CHK,
        SQ_S,
        SQ_W,
        MU_S,
        MU_W,
        NXT,
        X_S,
        X_W,
        Y_S,
        Y_W,
        CANON,
        FINISH
    } stateT;

    stateT        r_state;
    stateT        w_nextState;

    logic [254:0] r_x;
    logic [254:0] r_y;
    logic [254:0] r_z;
    logic [254:0] r_acc;
    logic [7:0]   r_i;
    logic [255:0] r_enc;
    logic         r_err;

    logic         w_mulStart;
    logic [254:0] w_opA;
    logic [254:0] w_opB;
    logic         w_mulDone;
    logic [254:0] w_mulResult;
    logic         w_zIsZero;
    logic [254:0] w_xCanon;
    logic [254:0] w_yCanon;

    mul_25519 u_mul (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_mulStart),
        .i_a      (w_opA),
        .i_b      (w_opB),
        .o_done   (w_mulDone),
        .o_result (w_mulResult)
    );

    // Z = 0 and Z = p are the only 255-bit encodings of zero mod p.
    assign w_zIsZero = (r_z == '0) || (r_z == P);

    // The multiplier already returns reduced values, but X and Y enter
    // unreduced, so the final canonicalisation stays as a safety net.
    assign w_xCanon = (r_x >= P) ? (r_x - P) : r_x;
    assign w_yCanon = (r_y >= P) ? (r_y - P) : r_y;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic plus the multiplier request. Each *_S state issues
    // exactly one single-cycle start with its operand pair; the matching
    // *_W state then waits for the done pulse, so only one product is ever
    // outstanding. The exponent bit is looked up before i is decremented.
    always_comb begin
        w_nextState = r_state;
        w_mulStart  = 1'b0;
        w_opA       = r_acc;
        w_opB       = r_acc;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = CHK;
                end
            end
            CHK: begin
                w_nextState = w_zIsZero ? FINISH : SQ_S;
            end
            SQ_S: begin
                w_mulStart  = 1'b1;
                w_nextState = SQ_W;
            end
            SQ_W: begin
                if (w_mulDone) begin
                    w_nextState = E[r_i] ? MU_S : NXT;
                end
            end
            MU_S: begin
                w_mulStart  = 1'b1;
                w_opB       = r_z;
                w_nextState = MU_W;
            end
            MU_W: begin
                if (w_mulDone) begin
                    w_nextState = NXT;
                end
            end
            NXT: begin
                w_nextState = (r_i == 8'd0) ? X_S : SQ_S;
            end
            X_S: begin
                w_mulStart  = 1'b1;
                w_opB       = r_x;
                w_nextState = X_W;
            end
            X_W: begin
                if (w_mulDone) begin
                    w_nextState = Y_S;
                end
            end
            Y_S: begin
                w_mulStart  = 1'b1;
                w_opB       = r_y;
                w_nextState = Y_W;
            end
            Y_W: begin
                if (w_mulDone) begin
                    w_nextState = CANON;
                end
            end
            CANON: begin
                w_nextState = FINISH;
            end
            FINISH: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Datapath registers. acc starts at Z because the top exponent bit is
    // a 1, which leaves bits 253..0 for the loop. enc_out and err are only
    // rewritten at the zero check and at canonicalisation, so they hold
    // their last result while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x   <= '0;
            r_y   <= '0;
            r_z   <= '0;
            r_acc <= '0;
            r_i   <= 8'd0;
            r_enc <= '0;
            r_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_x <= x_in;
                        r_y <= y_in;
                        r_z <= z_in;
                    end
                end
                CHK: begin
                    if (w_zIsZero) begin
                        r_enc <= '0;
                        r_err <= 1'b1;
                    end else begin
                        r_acc <= r_z;
                        r_i   <= 8'd253;
                        r_err <= 1'b0;
                    end
                end
                SQ_W, MU_W: begin
                    if (w_mulDone) begin
                        r_acc <= w_mulResult;
                    end
                end
                NXT: begin
                    if (r_i != 8'd0) begin
                        r_i <= r_i - 8'd1;
                    end
                end
                X_W: begin
                    if (w_mulDone) begin
                        r_x <= w_mulResult;
                    end
                end
                Y_W: begin
                    if (w_mulDone) begin
                        r_y <= w_mulResult;
                    end
                end
                CANON: begin
                    r_x   <= w_xCanon;
                    r_y   <= w_yCanon;
                    r_enc <= {w_xCanon[0], w_yCanon};
                end
                default: begin
                end
            endcase
        end
    end

    assign enc_out = r_enc;
    assign err     = r_err;
    assign done    = (r_state == FINISH);
    assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_point_encode_25519.sv
// ---------------------------------------------------------------------------
// tb_point_encode_25519
//
// Purpose:
//   Directed bench for point_encode_25519. Each request pushes its expected
//   encoding onto a queue; an independent monitor pops and compares every
//   time the design raises done. Expected encodings are the known Ed25519
//   constants (identity, base point B and its negation).
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------

module tb_point_encode_25519;

    localparam logic [254:0] P  = 255'h7fffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffed;
    localparam logic [254:0] XB = 255'h216936d3cd6e53fec0a4e231fdd6dc5c692cc7609525a7b2c9562d608f25d51a;
    localparam logic [254:0] YB = 255'h6666666666666666666666666666666666666666666666666666666666666658;
    localparam logic [255:0] ENC_B    = 256'h6666666666666666666666666666666666666666666666666666666666666658;
    localparam logic [255:0] ENC_NEGB = 256'he666666666666666666666666666666666666666666666666666666666666658;
    localparam logic [255:0] ENC_ID   = 256'h1;
    localparam int           DONE_BUDGET = 8000;

    logic         clk;
    logic         rst;
    logic         start;
    logic [254:0] x_in;
    logic [254:0] y_in;
    logic [254:0] z_in;
    logic [255:0] enc_out;
    logic         done;
    logic         err;
    logic         busy;

    int nCompared;
    int nMismatched;
    int mulStarts;

    logic [255:0] expEncQ[$];
    logic         expErrQ[$];
    string        expNameQ[$];

    point_encode_25519 dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .x_in    (x_in),
        .y_in    (y_in),
        .z_in    (z_in),
        .enc_out (enc_out),
        .done    (done),
        .err     (err),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expectation and tally it.
    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Doubling mod p, used to build the scaled projective copy of B.
    function automatic logic [254:0] modDouble(input logic [254:0] v);
        logic [255:0] t;
        t = {v, 1'b0};
        if (t >= {1'b0, P}) begin
            t = t - {1'b0, P};
        end
        return t[254:0];
    endfunction

    // Count multiplier start pulses as the multiplier sees them.
    initial begin
        mulStarts = 0;
        forever begin
            @(posedge clk);
            if (rst && dut.w_mulStart) begin
                mulStarts++;
            end
        end
    end

    // Monitor: every done pops the oldest expectation and compares.
    initial begin
        logic [255:0] eEnc;
        logic         eErr;
        string        eName;
        forever begin
            @(negedge clk);
            if (rst && done) begin
                if (expEncQ.size() == 0) begin
                    nCompared++;
                    nMismatched++;
                    $display("[TB] FAIL unexpectedDone: got done=1 enc=%h, expected no done", enc_out);
                end else begin
                    eEnc  = expEncQ.pop_front();
                    eErr  = expErrQ.pop_front();
                    eName = expNameQ.pop_front();
                    checkOutput({eName, ".enc"}, enc_out, eEnc);
                    checkOutput({eName, ".err"}, 256'(err), 256'(eErr));
                end
            end
        end
    end

    // Issue one request, wait (bounded) for done, then check the number of
    // multiplier starts and, when asked, the start-to-done latency.
    task automatic applyStimulus(input string name, input logic [254:0] x, input logic [254:0] y,
                                 input logic [254:0] z, input logic [255:0] expEnc, input logic expErr,
                                 input int expMuls, input int expLat);
        int base;
        int cyc;
        expEncQ.push_back(expEnc);
        expErrQ.push_back(expErr);
        expNameQ.push_back(name);
        @(negedge clk);
        x_in  = x;
        y_in  = y;
        z_in  = z;
        start = 1'b1;
        base  = mulStarts;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (!done && cyc < DONE_BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL %s.timeout: got no done after %0d cycles, expected done", name, cyc);
            void'(expEncQ.pop_back());
            void'(expErrQ.pop_back());
            void'(expNameQ.pop_back());
        end else begin
            if (expMuls >= 0) begin
                checkOutput({name, ".mulStarts"}, 256'(mulStarts - base), 256'(expMuls));
            end
            if (expLat >= 0) begin
                checkOutput({name, ".latency"}, 256'(cyc + 1), 256'(expLat));
            end
        end
    endtask

    initial begin
        int base;
        int cyc;
        start = 1'b0;
        x_in  = '0;
        y_in  = '0;
        z_in  = '0;
        nCompared   = 0;
        nMismatched = 0;
        rst = 1'b0;

        #1;
        checkOutput("reset.enc", enc_out, 256'h0);
        checkOutput("reset.done", 256'(done), 256'h0);
        checkOutput("reset.err", 256'(err), 256'h0);
        checkOutput("reset.busy", 256'(busy), 256'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        $display("[TB] identity and base point encodings");
        applyStimulus("identity", '0, 255'd1, 255'd1, ENC_ID, 1'b0, 508, -1);
        applyStimulus("baseB", XB, YB, 255'd1, ENC_B, 1'b0, -1, -1);
        applyStimulus("scaledB", modDouble(XB), modDouble(YB), 255'd2, ENC_B, 1'b0, -1, -1);
        applyStimulus("negB", P - XB, YB, 255'd1, ENC_NEGB, 1'b0, -1, -1);

        $display("[TB] degenerate Z and non-canonical y");
        applyStimulus("zZero", XB, YB, '0, 256'h0, 1'b1, 0, 2);
        applyStimulus("zIsP", XB, YB, P, 256'h0, 1'b1, 0, 2);
        applyStimulus("yPplus1", '0, P + 255'd1, 255'd1, ENC_ID, 1'b0, -1, -1);

        $display("[TB] start while busy is ignored");
        expEncQ.push_back(ENC_B);
        expErrQ.push_back(1'b0);
        expNameQ.push_back("busyB");
        @(negedge clk);
        x_in  = XB;
        y_in  = YB;
        z_in  = 255'd1;
        start = 1'b1;
        base  = mulStarts;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        checkOutput("busyHigh", 256'(busy), 256'h1);
        x_in  = '0;
        y_in  = 255'd1;
        z_in  = 255'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (!done && cyc < DONE_BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL busyB.timeout: got no done after %0d cycles, expected done", cyc);
            void'(expEncQ.pop_back());
            void'(expErrQ.pop_back());
            void'(expNameQ.pop_back());
        end else begin
            checkOutput("busyB.mulStarts", 256'(mulStarts - base), 256'd508);
        end
        repeat (30) @(negedge clk);
        checkOutput("busyIdleAfter", 256'(busy), 256'h0);

        $display("[TB] reset in the middle of an encode");
        @(negedge clk);
        x_in  = XB;
        y_in  = YB;
        z_in  = 255'd1;
        start = 1'b1;
        base  = mulStarts;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while ((mulStarts - base) < 200 && cyc < DONE_BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("midReset.reached200", 256'((mulStarts - base) >= 200), 256'h1);
        rst = 1'b0;
        #1;
        checkOutput("midReset.enc", enc_out, 256'h0);
        checkOutput("midReset.done", 256'(done), 256'h0);
        checkOutput("midReset.err", 256'(err), 256'h0);
        checkOutput("midReset.busy", 256'(busy), 256'h0);
        checkOutput("midReset.mulStart", 256'(dut.w_mulStart), 256'h0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        checkOutput("afterReset.busy", 256'(busy), 256'h0);
        applyStimulus("postResetB", XB, YB, 255'd1, ENC_B, 1'b0, 508, -1);

        repeat (5) @(negedge clk);
        checkOutput("pendingExpectations", 256'(expEncQ.size()), 256'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
